// File: rtl/fu_dispatch_queues_if.sv
// Dispatch, wakeup and issue signals for fu_dispatch_queues.
// The master side is rename/dispatch plus the FUs; the slave side is the queue block.
interface fu_dispatch_queues_if #(
  parameter int FU_COUNT     = 4,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE   = 4,
  parameter int FUC_BITS     = 2
);
  localparam int CNT_BITS = $clog2(QUEUE_SIZE + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [FUC_BITS-1:0]     in_fu_choice;
  logic [INST_ID_BITS-1:0] in_inst_id;
  logic [31:0]             in_raw_instr;
  logic [63:0]             in_pc;
  logic                    in_prn_input_valid  [MAX_OPERANDS];
  logic                    in_prn_input_ready  [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     in_prn_input        [MAX_OPERANDS];
  logic                    in_prn_output_valid [MAX_OPERANDS];
  logic [PRN_BITS-1:0]     in_prn_output       [MAX_OPERANDS];

  logic                    wakeup_valid [FU_COUNT][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     wakeup_prn   [FU_COUNT][MAX_OPERANDS];
  logic                    flush;

  logic                    queue_ready [FU_COUNT];
  logic [CNT_BITS-1:0]     queue_count [FU_COUNT];

  logic                    fu_issue_valid            [FU_COUNT];
  logic                    fu_issue_ready            [FU_COUNT];
  logic [INST_ID_BITS-1:0] fu_issue_inst_id          [FU_COUNT];
  logic [31:0]             fu_issue_raw_instr        [FU_COUNT];
  logic [63:0]             fu_issue_pc               [FU_COUNT];
  logic [PRN_BITS-1:0]     fu_issue_prn_input        [FU_COUNT][MAX_OPERANDS];
  logic                    fu_issue_prn_output_valid [FU_COUNT][MAX_OPERANDS];
  logic [PRN_BITS-1:0]     fu_issue_prn_output       [FU_COUNT][MAX_OPERANDS];

  modport master (
    output in_valid, in_fu_choice, in_inst_id, in_raw_instr, in_pc,
           in_prn_input_valid, in_prn_input_ready, in_prn_input,
           in_prn_output_valid, in_prn_output,
           wakeup_valid, wakeup_prn, flush, fu_issue_ready,
    input  in_ready, queue_ready, queue_count,
           fu_issue_valid, fu_issue_inst_id, fu_issue_raw_instr, fu_issue_pc,
           fu_issue_prn_input, fu_issue_prn_output_valid, fu_issue_prn_output
  );

  modport slave (
    input  in_valid, in_fu_choice, in_inst_id, in_raw_instr, in_pc,
           in_prn_input_valid, in_prn_input_ready, in_prn_input,
           in_prn_output_valid, in_prn_output,
           wakeup_valid, wakeup_prn, flush, fu_issue_ready,
    output in_ready, queue_ready, queue_count,
           fu_issue_valid, fu_issue_inst_id, fu_issue_raw_instr, fu_issue_pc,
           fu_issue_prn_input, fu_issue_prn_output_valid, fu_issue_prn_output
  );
endinterface

// File: rtl/fu_dispatch_queues.sv
// Per-FU in-order dispatch queues with operand wakeup tracking and valid/ready issue.
// Optional FU_DISPATCH_WAKEUP_BYPASS_EN lets a same-cycle wakeup make the head issue immediately.
module fu_dispatch_queues #(
  parameter int FU_COUNT     = 4,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE   = 4,
  parameter int FUC_BITS     = 2
) (
  input logic clk,
  input logic rst,
  fu_dispatch_queues_if.slave bus
);
  localparam int PTR_BITS = $clog2(QUEUE_SIZE);
  localparam int CNT_BITS = $clog2(QUEUE_SIZE + 1);
  localparam int LANES    = FU_COUNT * MAX_OPERANDS;

  typedef logic [PTR_BITS-1:0] ptr_t;
  typedef logic [CNT_BITS-1:0] cnt_t;
  typedef logic [MAX_OPERANDS-1:0] ops_t;
  typedef logic [LANES-1:0] lane_v_t;
  typedef logic [LANES-1:0][PRN_BITS-1:0] lane_p_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                inst_id;
    logic [31:0]                            raw_instr;
    logic [63:0]                            pc;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_in;
    logic [MAX_OPERANDS-1:0]                prn_out_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_out;
  } entry_t;

  ptr_t   head_q  [FU_COUNT];
  ptr_t   head_d  [FU_COUNT];
  ptr_t   tail_q  [FU_COUNT];
  ptr_t   tail_d  [FU_COUNT];
  cnt_t   count_q [FU_COUNT];
  cnt_t   count_d [FU_COUNT];
  ops_t   rdy_q   [FU_COUNT][QUEUE_SIZE];
  ops_t   rdy_d   [FU_COUNT][QUEUE_SIZE];
  entry_t mem_q   [FU_COUNT][QUEUE_SIZE];

  lane_v_t             wk_v;
  lane_p_t             wk_p;
  ops_t                wake_ent [FU_COUNT][QUEUE_SIZE];
  ops_t                head_ops [FU_COUNT];
  entry_t              head_ent [FU_COUNT];
  entry_t              in_entry;
  ops_t                in_rdy;
  logic [FUC_BITS-1:0] choice;
  logic                in_ready;
  logic                qready      [FU_COUNT];
  logic                issue_valid [FU_COUNT];
  logic                push        [FU_COUNT];
  logic                pop         [FU_COUNT];

  function automatic logic lane_hit(input logic [PRN_BITS-1:0] prn,
                                    input lane_v_t lv, input lane_p_t lp);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (lv[i] && (lp[i] == prn)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(QUEUE_SIZE - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Flatten the 2-D wakeup broadcast into one lane vector for matching.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    wk_v = '0;
    wk_p = '0;
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        wk_v[f*MAX_OPERANDS + o] = bus.wakeup_valid[f][o];
        wk_p[f*MAX_OPERANDS + o] = bus.wakeup_prn[f][o];
      end
    end
  end

  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      for (int e = 0; e < QUEUE_SIZE; e++) begin
        wake_ent[f][e] = '0;
        for (int o = 0; o < MAX_OPERANDS; o++) begin
          wake_ent[f][e][o] = lane_hit(mem_q[f][e].prn_in[o], wk_v, wk_p);
        end
      end
    end
  end

  // Incoming entry; an operand is ready if unused, already ready, or woken this very cycle.
  always_comb begin
    in_entry           = '0;
    in_rdy             = '0;
    in_entry.inst_id   = bus.in_inst_id;
    in_entry.raw_instr = bus.in_raw_instr;
    in_entry.pc        = bus.in_pc;
    for (int o = 0; o < MAX_OPERANDS; o++) begin
      in_entry.prn_in[o]        = bus.in_prn_input[o];
      in_entry.prn_out_valid[o] = bus.in_prn_output_valid[o];
      in_entry.prn_out[o]       = bus.in_prn_output[o];
      in_rdy[o] = !bus.in_prn_input_valid[o] || bus.in_prn_input_ready[o] ||
                  lane_hit(bus.in_prn_input[o], wk_v, wk_p);
    end
  end

  // Out-of-range FU choices are accepted and silently dropped.
  always_comb begin
    choice   = bus.in_fu_choice;
    in_ready = 1'b1;
    for (int f = 0; f < FU_COUNT; f++) begin
      qready[f] = (count_q[f] != cnt_t'(QUEUE_SIZE));
      if (int'(choice) == f) in_ready = qready[f];
    end
  end

  always_comb begin
    for (int f = 0; f < FU_COUNT; f++) begin
      head_ops[f] = rdy_q[f][head_q[f]];
`ifdef FU_DISPATCH_WAKEUP_BYPASS_EN
      head_ops[f] = head_ops[f] | wake_ent[f][head_q[f]];
`endif
      issue_valid[f] = (count_q[f] != '0) && (&head_ops[f]) && !bus.flush;
      push[f] = bus.in_valid && in_ready && !bus.flush && (int'(choice) == f);
      pop[f]  = issue_valid[f] && bus.fu_issue_ready[f];

      head_d[f]  = head_q[f];
      tail_d[f]  = tail_q[f];
      count_d[f] = count_q[f];
      if (bus.flush) begin
        head_d[f]  = '0;
        tail_d[f]  = '0;
        count_d[f] = '0;
      end else begin
        if (pop[f])  head_d[f] = ptr_inc(head_q[f]);
        if (push[f]) tail_d[f] = ptr_inc(tail_q[f]);
        count_d[f] = count_q[f] + cnt_t'(push[f]) - cnt_t'(pop[f]);
      end

      // Ready bits only ever set; a new entry overwrites the slot's bits wholesale.
      for (int e = 0; e < QUEUE_SIZE; e++) begin
        rdy_d[f][e] = rdy_q[f][e] | wake_ent[f][e];
        if (push[f] && (tail_q[f] == ptr_t'(e))) rdy_d[f][e] = in_rdy;
      end
    end
  end

  always_comb begin
    bus.in_ready = in_ready;
    for (int f = 0; f < FU_COUNT; f++) begin
      bus.queue_ready[f]        = qready[f];
      bus.queue_count[f]        = count_q[f];
      bus.fu_issue_valid[f]     = issue_valid[f];
      head_ent[f]               = issue_valid[f] ? mem_q[f][head_q[f]] : '0;
      bus.fu_issue_inst_id[f]   = head_ent[f].inst_id;
      bus.fu_issue_raw_instr[f] = head_ent[f].raw_instr;
      bus.fu_issue_pc[f]        = head_ent[f].pc;
      for (int o = 0; o < MAX_OPERANDS; o++) begin
        bus.fu_issue_prn_input[f][o]        = head_ent[f].prn_in[o];
        bus.fu_issue_prn_output_valid[f][o] = head_ent[f].prn_out_valid[o];
        bus.fu_issue_prn_output[f][o]       = head_ent[f].prn_out[o];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FU_COUNT; f++) begin
        head_q[f]  <= '0;
        tail_q[f]  <= '0;
        count_q[f] <= '0;
        for (int e = 0; e < QUEUE_SIZE; e++) rdy_q[f][e] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdy_q   <= rdy_d;
    end
  end

  // NOTE: payload storage has no reset; a slot is only read once count covers it, after a write.
  always_ff @(posedge clk) begin
    for (int f = 0; f < FU_COUNT; f++) begin
      if (push[f]) mem_q[f][tail_q[f]] <= in_entry;
    end
  end
endmodule

// File: doc/fu_dispatch_queues.md
# fu_dispatch_queues

Parametrised successor to the single-slot instruction demux. Steers each renamed instruction into one of `FU_COUNT` per-functional-unit in-order queues of depth `QUEUE_SIZE`, tracks operand readiness per entry from the PRN wakeup broadcast, and presents each queue head to its functional unit through a valid/ready issue handshake. Sits between rename/dispatch and the functional units; also provides per-FU backpressure and a global flush.

## Interface
- `FU_COUNT`, 4, number of functional units / queues
- `INST_ID_BITS`, 6, instruction ID width
- `PRN_BITS`, 6, physical register number width
- `MAX_OPERANDS`, 3, source/destination slots per instruction
- `QUEUE_SIZE`, 4, entries per queue (≥2, need not be a power of two)
- `FUC_BITS`, 2, FU select width

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  dispatch request
- `in_ready`  out  1  dispatch accepted this cycle
- `in_fu_choice`  in  FUC_BITS  target queue
- `in_inst_id`  in  INST_ID_BITS; `in_raw_instr` in 32; `in_pc` in 64
- `in_prn_input_valid[MAX_OPERANDS]`, `in_prn_input_ready[MAX_OPERANDS]`  in  1 each
- `in_prn_input[MAX_OPERANDS]`  in  PRN_BITS
- `in_prn_output_valid[MAX_OPERANDS]` in 1; `in_prn_output[MAX_OPERANDS]` in PRN_BITS
- `wakeup_valid[FU_COUNT][MAX_OPERANDS]` in 1; `wakeup_prn[FU_COUNT][MAX_OPERANDS]` in PRN_BITS; PRN-ready broadcast
- `flush`  in  1  discard all queued instructions
- `queue_ready[FU_COUNT]`  out  1  queue has a free entry
- `queue_count[FU_COUNT]`  out  $clog2(QUEUE_SIZE+1)  occupancy
- `fu_issue_valid[FU_COUNT]` out 1; `fu_issue_ready[FU_COUNT]` in 1
- `fu_issue_inst_id`, `fu_issue_raw_instr`, `fu_issue_pc`, `fu_issue_prn_input`, `fu_issue_prn_output_valid`, `fu_issue_prn_output`: per-FU copies of head payload, out

## Operation
- Per queue: circular buffer, head/tail pointers wrap modulo `QUEUE_SIZE`, count register.
- `queue_ready[f]` = count[f] < QUEUE_SIZE, from registered count only. A pop in the same cycle does not free a slot for the same-cycle push.
- `in_ready` = `queue_ready[in_fu_choice]` when `in_fu_choice < FU_COUNT`. Otherwise `in_ready`=1 and the instruction is dropped.
- Enqueue on `in_valid && in_ready && !flush`. Captured operand ready bit = `!prn_input_valid || prn_input_ready || (any wakeup lane matches prn_input this cycle)`.
- Every cycle, every resident valid entry sets its operand ready when any of the `FU_COUNT*MAX_OPERANDS` wakeup lanes has a matching PRN. Ready bits never clear.
- Head eligible when count>0 and all operands ready. `fu_issue_valid[f]` = eligible && !flush. Pop on valid && ready. Strictly in-order per queue; queues are independent.
- Payload outputs are driven 0 when `fu_issue_valid` is 0.
- `flush`: counts and pointers cleared at the next edge. Enqueue and pop in the flush cycle are ignored.

## Timing
- Reset: all counts/pointers 0, `queue_ready` all 1, `in_ready` 1, `fu_issue_valid` 0, issue payloads 0, `queue_count` 0.
- Enqueue at edge N → earliest `fu_issue_valid` in cycle N+1.
- Wakeup in cycle N on a resident head → eligible in N+1 (N with bypass, see Configuration).
- Full queue: push blocked while count=QUEUE_SIZE, even with a simultaneous pop; reopens the cycle after the pop.
- Reset mid-operation: all entries lost immediately (asynchronous), outputs at reset values.

## Configuration
- `FU_DISPATCH_WAKEUP_BYPASS_EN` defined: head eligibility also ORs in current-cycle wakeup matches. Wakeup in cycle N issues in cycle N (combinational wakeup→issue path).
- Undefined: eligibility uses registered ready bits only, giving one-cycle wakeup-to-issue. Capture-on-enqueue wakeup matching is present in both builds.

## Test plan
- Reset, then dispatch id=5 to FU 2 with all operands ready → `fu_issue_valid[2]`=1 next cycle, `fu_issue_inst_id[2]`=5, other FUs 0.
- Fill FU 0 with 4 entries, hold `fu_issue_ready[0]`=0 → `queue_ready[0]`=0, `in_ready`=0 for fu_choice=0, `queue_count[0]`=4; a push to FU 1 is still accepted. Pop one → `queue_ready[0]`=1 the following cycle.
- Enqueue id=7 with operand prn 12 not ready; assert `wakeup_prn[3][1]`=12 at cycle N → issue at N+1 (N with bypass macro).
- Enqueue with `wakeup_prn`=12 in the same cycle as operand prn 12 → operand captured ready, issues next cycle. A non-ready head blocks a ready younger entry in the same queue.
- Push 6 then pop 6 through FU 3 with QUEUE_SIZE=3 → IDs issue in order across pointer wrap.
- Three queues partially full, assert `flush` together with a push → all counts 0, push discarded, `fu_issue_valid` 0 that cycle. `in_fu_choice`=3 with FU_COUNT=3 → `in_ready`=1, nothing enqueued.
